proc_control: RTL and testbench

- Multi-cycle control unit for the 16-bit datapath. Sits directly upstream of the bus multiplexer.
- Fetches a 9-bit instruction word, then sequences the bus select code, register load enables, accumulator A / result G enables and the add/sub control over 1–3 execute steps.
- Pulses done when an instruction completes.
- Bus select encoding: 4'h0–4'h7 = R0–R7, 4'h8 = DIN (instruction/immediate channel), 4'h9 = G result register. The bus mux is extended to 10 channels, with G on channel 9.

---
 rtl/proc_pkg.sv | 32 +++
 rtl/proc_control_if.sv | 32 +++
 rtl/proc_control_dec3to8.sv | 11 +
 rtl/proc_control.sv | 100 ++++++++++
 tb/tb_proc_control.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared constants and types for the proc_control multi-cycle control unit.
// Holds the opcode map, bus select codes, instruction field positions and FSM states.
package proc_pkg;

  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 4;
  localparam int IR_W     = 9;

  // Instruction layout: opcode [8:6], X [5:3], Y [2:0]
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int X_HI  = 5;
  localparam int X_LO  = 3;
  localparam int Y_HI  = 2;
  localparam int Y_LO  = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [SEL_W-1:0] SEL_DIN = 4'h8;
  localparam logic [SEL_W-1:0] SEL_G   = 4'h9;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

endpackage

// File: rtl/proc_control_if.sv
// Control-unit port bundle: run/instruction in, datapath control and trace out.
// The master side is the control unit; the slave side is the datapath/environment.
interface proc_control_if #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 4,
  parameter int IR_W     = 9
);
  // Handshake: run is a request seen only while idle (T0); the unit answers with a
  // single-cycle done pulse when that instruction retires, and busy covers T1-T3.
  logic                run;
  logic [IR_W-1:0]     instr_in;
  logic [SEL_W-1:0]    sel;
  logic [NUM_REGS-1:0] r_in;
  logic                a_in;
  logic                g_in;
  logic                add_sub;
  logic                done;
  logic                illegal;
  logic                busy;
  logic [IR_W-1:0]     ir;
  logic [1:0]          state;

  modport master (
    input  run, instr_in,
    output sel, r_in, a_in, g_in, add_sub, done, illegal, busy, ir, state
  );

  modport slave (
    output run, instr_in,
    input  sel, r_in, a_in, g_in, add_sub, done, illegal, busy, ir, state
  );
endinterface

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable, turning the X field into a register load enable.
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);
  always_comb begin
    onehot = 8'h00;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/proc_control.sv
// Multi-cycle control unit: fetches a 9-bit instruction and sequences bus select,
// register/accumulator/G enables and add/sub over T1-T3; outputs decode (state, ir).
module proc_control
  import proc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  proc_control_if.master bus
);

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q;
  logic [2:0]      op_f, x_f, y_f;
  logic            dec_en;
  logic [7:0]      dec_onehot;

  assign op_f = ir_q[OP_HI:OP_LO];
  assign x_f  = ir_q[X_HI:X_LO];
  assign y_f  = ir_q[Y_HI:Y_LO];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T0 && bus.run) ir_q <= bus.instr_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.sel     = '0;
    dec_en      = 1'b0;
    bus.a_in    = 1'b0;
    bus.g_in    = 1'b0;
    bus.add_sub = 1'b0;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.busy    = 1'b0;
    case (state_q)
      T0: begin
        if (bus.run) state_d = T1;
      end
      T1: begin
        bus.busy = 1'b1;
        case (op_f)
          OP_MV: begin
            bus.sel  = SEL_W'(y_f);
            dec_en   = 1'b1;
            bus.done = 1'b1;
            state_d  = T0;
          end
          OP_MVI: begin
            bus.sel  = SEL_DIN;
            dec_en   = 1'b1;
            bus.done = 1'b1;
            state_d  = T0;
          end
          OP_ADD, OP_SUB: begin
            bus.sel  = SEL_W'(x_f);
            bus.a_in = 1'b1;
            state_d  = T2;
          end
          default: begin
            bus.done    = 1'b1;
            bus.illegal = 1'b1;
            state_d     = T0;
          end
        endcase
      end
      T2: begin
        bus.busy    = 1'b1;
        bus.sel     = SEL_W'(y_f);
        bus.g_in    = 1'b1;
        bus.add_sub = ir_q[OP_LO];
        state_d     = T3;
      end
      T3: begin
        bus.busy = 1'b1;
        bus.sel  = SEL_G;
        dec_en   = 1'b1;
        bus.done = 1'b1;
        state_d  = T0;
      end
      default: state_d = T0;
    endcase
  end

  dec3to8 u_dec (
    .idx    (x_f),
    .en     (dec_en),
    .onehot (dec_onehot)
  );

  assign bus.r_in  = dec_onehot;
  assign bus.ir    = ir_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: hand-computed control words for each opcode,
// reset abort, back-to-back fetch and instruction-register stability.
module tb_proc_control;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  proc_control_if #(.NUM_REGS(8), .SEL_W(4), .IR_W(9)) bus ();

  proc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_ctl(input string tag, input logic [3:0] sel, input logic [7:0] r_in,
                         input logic a_in, input logic g_in, input logic add_sub,
                         input logic done, input logic illegal, input logic busy);
    chk({tag, ".sel"},     32'(bus.sel),     32'(sel));
    chk({tag, ".r_in"},    32'(bus.r_in),    32'(r_in));
    chk({tag, ".a_in"},    32'(bus.a_in),    32'(a_in));
    chk({tag, ".g_in"},    32'(bus.g_in),    32'(g_in));
    chk({tag, ".add_sub"}, 32'(bus.add_sub), 32'(add_sub));
    chk({tag, ".done"},    32'(bus.done),    32'(done));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(illegal));
    chk({tag, ".busy"},    32'(bus.busy),    32'(busy));
  endtask

  // driver: advance one cycle, landing 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [8:0] instr);
    bus.run      = 1'b1;
    bus.instr_in = instr;
    step();
    bus.run      = 1'b0;
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rst          = 1'b1;
    bus.run      = 1'b0;
    bus.instr_in = 9'h000;
    step();
    chk_ctl("reset", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);
    chk("reset.ir", 32'(bus.ir), 32'h0);
    chk("reset.state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    step();
    chk_ctl("idle", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);

    // mv R5,R2
    issue(9'b000_101_010);
    chk_ctl("mv.t1", 4'h2, 8'h20, 0, 0, 0, 1, 0, 1);
    chk("mv.ir", 32'(bus.ir), 32'(9'b000_101_010));
    step();
    chk_ctl("mv.after", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);

    // mvi R0,#D
    issue(9'b001_000_000);
    chk_ctl("mvi.t1", 4'h8, 8'h01, 0, 0, 0, 1, 0, 1);
    step();
    chk("mvi.after.busy", 32'(bus.busy), 32'd0);

    // sub R7,R1
    issue(9'b011_111_001);
    chk_ctl("sub.t1", 4'h7, 8'h00, 1, 0, 0, 0, 0, 1);
    step();
    chk_ctl("sub.t2", 4'h1, 8'h00, 0, 1, 1, 0, 0, 1);
    step();
    chk_ctl("sub.t3", 4'h9, 8'h80, 0, 0, 0, 1, 0, 1);
    step();
    chk_ctl("sub.after", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);

    // add R3,R3: T2 must select Y and add
    issue(9'b010_011_011);
    chk_ctl("add.t1", 4'h3, 8'h00, 1, 0, 0, 0, 0, 1);
    step();
    chk_ctl("add.t2", 4'h3, 8'h00, 0, 1, 0, 0, 0, 1);
    step();
    chk_ctl("add.t3", 4'h9, 8'h08, 0, 0, 0, 1, 0, 1);
    step();

    // illegal opcode 110
    issue(9'b110_011_011);
    chk_ctl("ill.t1", 4'h0, 8'h00, 0, 0, 0, 1, 1, 1);
    step();
    chk_ctl("ill.after", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);
    chk("ill.state", 32'(bus.state), 32'd0);

    // back-to-back: add R1,R1 then mv R2,R1 with run held high.
    // add occupies cycles 1..3 after its fetch edge, returns to T0 in cycle 4,
    // mv is fetched at the end of cycle 4 and retires in cycle 5.
    bus.run      = 1'b1;
    bus.instr_in = 9'b010_001_001;
    step();
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("b2b.done.c%0d", c), 32'(bus.done), 32'((c == 3) || (c == 5)));
      if (c <= 4) chk($sformatf("b2b.ir.c%0d", c), 32'(bus.ir), 32'(9'b010_001_001));
      if (c == 3) chk("b2b.add.r_in", 32'(bus.r_in), 32'h02);
      if (c == 5) begin
        chk("b2b.mv.ir", 32'(bus.ir), 32'(9'b000_010_001));
        chk("b2b.mv.sel", 32'(bus.sel), 32'h1);
        chk("b2b.mv.r_in", 32'(bus.r_in), 32'h04);
        bus.run = 1'b0;
      end
      case (c)
        1: bus.instr_in = 9'h1FF;
        2: bus.instr_in = 9'h0AA;
        3: bus.instr_in = 9'b000_010_001;
        default: ;
      endcase
      step();
    end

    // reset asserted in the middle of T2 of an add aborts it
    issue(9'b010_011_011);
    step();
    chk("abort.pre.g_in", 32'(bus.g_in), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_ctl("abort.async", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);
    chk("abort.state", 32'(bus.state), 32'd0);
    chk("abort.ir", 32'(bus.ir), 32'h0);
    step();
    chk_ctl("abort.held", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_ctl("abort.idle", 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
